// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM encoding, register-zero index, counter width.
// Pure types and constants; no timing or flow control.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_ZERO  = 5'd0;
   localparam int         CNT_W_DEF = 32;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: value reflects an increment one cycle later.
// Holds at all-ones; synchronous active-low clear.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         o_cnt <= '0;
      end else if (i_inc && (o_cnt != {W{1'b1}})) begin
         o_cnt <= o_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush controls, consumed on the same edge.
// One bubble per load-use; branch > jump > load-use; saturating stall and flush counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic [4:0]       i_ifid_rs,
   input  logic [4:0]       i_ifid_rt,
   input  logic             i_ifid_rt_src,
   input  logic             i_idex_memRead,
   input  logic [4:0]       i_idex_rt,
   input  logic             i_idex_jump,
   input  logic             i_exmem_branch_taken,
   output logic             o_pc_write,
   output logic             o_ifid_write,
   output logic             o_ifid_flush,
   output logic             o_idex_bubble,
   output logic             o_exmem_flush,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   hz_state_t state, state_nxt;
   logic      load_use;
   logic      br;
   logic      jmp;

   assign br  = i_exmem_branch_taken;
   assign jmp = i_idex_jump;

   assign load_use = i_idex_memRead && (i_idex_rt != REG_ZERO) &&
                     ((i_idex_rt == i_ifid_rs) ||
                      (i_ifid_rt_src && (i_idex_rt == i_ifid_rt)));

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      o_pc_write    = 1'b1;
      o_ifid_write  = 1'b1;
      o_ifid_flush  = 1'b0;
      o_idex_bubble = 1'b0;
      o_exmem_flush = 1'b0;
      state_nxt     = RUN;

      if (i_rst_n) begin
         // Redirects are honoured identically in every state; only RUN reacts to load_use.
         if (br) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            o_exmem_flush = 1'b1;
            state_nxt     = FLUSH;
         end else if (jmp) begin
            o_ifid_flush  = 1'b1;
            o_idex_bubble = 1'b1;
            state_nxt     = FLUSH;
         end else begin
            case (state)
               RUN: begin
                  if (load_use) begin
                     o_pc_write    = 1'b0;
                     o_ifid_write  = 1'b0;
                     o_idex_bubble = 1'b1;
                     state_nxt     = STALL;
                  end
               end
               STALL:   state_nxt = RUN;
               FLUSH:   state_nxt = RUN;
               default: state_nxt = RUN;
            endcase
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_inc   (~o_pc_write),
      .o_cnt   (o_stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .i_inc   (o_ifid_flush),
      .o_cnt   (o_flush_cnt)
   );

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller driving the stall and flush controls of the PC, IF/ID, ID/EX and EX/MEM buffers. It watches the ID/EX buffer outputs and the IF/ID instruction fields. It detects load-use hazards, taken branches (resolved at EX/MEM) and jumps (resolved at ID/EX). It then asserts bubble/flush/hold controls back into the buffers, and keeps saturating stall and flush event counters.

## Interface
- CNT_W, 32: width of the performance counters.
- clk  in  1  pipeline clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; synchronous and active-low.
- i_ifid_rs  in  5  rs field of the instruction in IF/ID.
- i_ifid_rt  in  5  rt field of the instruction in IF/ID.
- i_ifid_rt_src  in  1  1 when the IF/ID instruction reads rt (R-type, beq, sw).
- i_idex_memRead  in  1  ID/EX memRead output.
- i_idex_rt  in  5  ID/EX rt output, the load destination.
- i_idex_jump  in  1  ID/EX jump output.
- i_exmem_branch_taken  in  1  EX/MEM branch AND zero.
- o_pc_write  out  1  1 = PC may update.
- o_ifid_write  out  1  1 = IF/ID may load.
- o_ifid_flush  out  1  clear IF/ID to a nop on the next edge.
- o_idex_bubble  out  1  load all-zero controls into ID/EX on the next edge.
- o_exmem_flush  out  1  clear EX/MEM controls on the next edge.
- o_stall_cnt  out  CNT_W  load-use stall cycles since reset, saturating.
- o_flush_cnt  out  CNT_W  flush events since reset, saturating.

## Operation
- Hazard terms, combinational:
  - load_use = i_idex_memRead and i_idex_rt != 0, and either i_idex_rt == i_ifid_rs, or (i_ifid_rt_src and i_idex_rt == i_ifid_rt).
  - br = i_exmem_branch_taken.
  - jmp = i_idex_jump.
- FSM states: RUN, STALL, FLUSH. Controls are Mealy outputs of state plus hazard terms.
- Priority per cycle: br > jmp > load_use.
- RUN:
  - br: o_ifid_flush=1, o_idex_bubble=1, o_exmem_flush=1, o_pc_write=1; go to FLUSH.
  - else jmp: o_ifid_flush=1, o_idex_bubble=1, o_pc_write=1; go to FLUSH.
  - else load_use: o_pc_write=0, o_ifid_write=0, o_idex_bubble=1; go to STALL.
  - else: all pass, meaning o_pc_write=1, o_ifid_write=1 and the other controls 0.
- STALL: exactly one stall cycle per load. load_use is ignored in this state, because ID/EX now holds a bubble. br and jmp still apply with the same priority and outputs as in RUN, and move to FLUSH. Otherwise all pass; return to RUN.
- FLUSH: one recovery cycle. load_use is ignored, because flushed stages carry zero controls. br or jmp is honoured as in RUN and stays in FLUSH. Otherwise all pass; return to RUN.
- o_stall_cnt increments by 1 on each cycle o_pc_write=0.
- o_flush_cnt increments by 1 on each cycle o_ifid_flush=1.
- Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing
- Controls are combinational from the current state and inputs, and are consumed by the buffers on the same rising edge.
- FSM state and counters are registered; counters reflect an event one cycle after it.
- Reset (i_rst_n=0 at an edge): state=RUN and both counters 0. Reset wins over any event in the same cycle.
- While i_rst_n=0, outputs are forced to o_pc_write=1, o_ifid_write=1 and the other controls 0. This holds mid-stall or mid-flush.
- Load-use latency: one bubble cycle. The dependent instruction enters ID/EX two edges after the load entered EX.
- A branch taken in the same cycle as load_use: flush only, no stall, stall counter unchanged.
- No register-0 hazards are detected.

## Structure
- Shared pipeline package holds:
  - FSM state encoding: RUN=2'd0, STALL=2'd1, FLUSH=2'd2.
  - REG_ZERO=5'd0.
  - Default CNT_W.
- Sub-module sat_counter (parameter W; inputs clk, i_rst_n, i_inc; output o_cnt) is instantiated twice.
- Everything else stays flat.

## Test plan
- Reset: hold i_rst_n=0 for 2 cycles with load_use active. Expect o_pc_write=1, o_ifid_write=1, other controls 0, and both counters 0.
- Load-use: i_idex_memRead=1, i_idex_rt=5'd8, i_ifid_rs=5'd8. Expect one cycle of o_pc_write=0, o_ifid_write=0, o_idex_bubble=1, then a pass cycle, then o_stall_cnt=1. Repeat with rt=0: expect no stall.
- rt source: i_idex_rt=9, i_ifid_rt=9. With i_ifid_rt_src=0 expect no stall; with i_ifid_rt_src=1 expect a stall.
- Branch vs load-use collision: i_exmem_branch_taken=1 together with a load_use match. Expect o_ifid_flush, o_idex_bubble and o_exmem_flush all 1, o_pc_write=1, o_flush_cnt +1, o_stall_cnt unchanged.
- Jump then back-to-back branch: i_idex_jump=1, then i_exmem_branch_taken=1 on the next cycle. Expect two consecutive flush cycles, state stays in FLUSH, o_flush_cnt=2.
- Saturation: CNT_W=3, 9 consecutive load-use/pass pairs. Expect o_stall_cnt to stop at 7.
